// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory request responder.
// Holds the FSM state encoding, the grant encoding and the timeout load word.
package mem_resp_pkg;

    localparam int WORD_W_DEFAULT = 32;

    // Load word returned when the RAM never answers.
    localparam logic [31:0] BAD_WORD = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for a RAM access.
// Flags terminal count once TIMEOUT-1 cycles have been counted.
module mem_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic srst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mem_request_responder.sv
// Memory-side endpoint: arbitrates instruction/data requests onto one RAM port,
// waits for ram_ready (with a timeout watchdog) and returns a one-cycle hit.
module mem_request_responder
    import mem_resp_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              err
);

    localparam logic [WORD_W-1:0] BAD_LOAD = WORD_W'(BAD_WORD);

    state_t            r_state, r_state_next;
    grant_t            r_grant, r_grant_next;
    grant_t            r_last, r_last_next;
    logic [WORD_W-1:0] r_addr, r_addr_next;
    logic [WORD_W-1:0] r_store, r_store_next;
    logic [WORD_W-1:0] r_data, r_data_next;
    logic              r_write, r_write_next;
    logic              r_err, r_err_next;

    logic w_d_pend;
    logic w_tc;
    logic w_clear;
    logic w_inc;
    logic w_resp_i;
    logic w_resp_d;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .srst    (RST),
        .i_clear (w_clear),
        .i_inc   (w_inc),
        .o_tc    (w_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_grant <= GRANT_I;
            r_last  <= GRANT_I;
            r_addr  <= '0;
            r_store <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_state_next;
            r_grant <= r_grant_next;
            r_last  <= r_last_next;
            r_addr  <= r_addr_next;
            r_store <= r_store_next;
            r_data  <= r_data_next;
            r_write <= r_write_next;
            r_err   <= r_err_next;
        end
    end

    assign w_d_pend = dmemREN | dmemWEN;

    always_comb begin
        r_state_next = r_state;
        r_grant_next = r_grant;
        r_last_next  = r_last;
        r_addr_next  = r_addr;
        r_store_next = r_store;
        r_data_next  = r_data;
        r_write_next = r_write;
        r_err_next   = r_err;
        w_clear      = 1'b1;
        w_inc        = 1'b0;

        unique case (r_state)
            IDLE: begin
                // On a tie the side that was not served last time wins.
                if (imemREN && (!w_d_pend || r_last == GRANT_D)) begin
                    r_grant_next = GRANT_I;
                    r_addr_next  = imemaddr;
                    r_write_next = 1'b0;
                    r_state_next = IACC;
                end else if (w_d_pend) begin
                    r_grant_next = GRANT_D;
                    r_addr_next  = dmemaddr;
                    r_store_next = dmemstore;
                    r_write_next = dmemWEN;
                    r_err_next   = r_err | (dmemREN & dmemWEN);
                    r_state_next = DACC;
                end
            end
            IACC, DACC: begin
                w_clear = 1'b0;
                if (ram_ready) begin
                    r_data_next  = ramload;
                    r_state_next = RESP;
                end else if (w_tc) begin
                    r_data_next  = BAD_LOAD;
                    r_err_next   = 1'b1;
                    r_state_next = RESP;
                end else begin
                    w_inc = 1'b1;
                end
            end
            RESP: begin
                r_last_next  = r_grant;
                r_state_next = IDLE;
            end
            default: r_state_next = IDLE;
        endcase
    end

    // A hit is only returned if the requester is still asking for it.
    assign w_resp_i = (r_state == RESP) && (r_grant == GRANT_I);
    assign w_resp_d = (r_state == RESP) && (r_grant == GRANT_D);

    assign ihit     = w_resp_i && imemREN;
    assign dhit     = w_resp_d && w_d_pend;
    assign imemload = w_resp_i ? r_data : '0;
    assign dmemload = (w_resp_d && !r_write) ? r_data : '0;

    assign ramREN   = (r_state == IACC) || ((r_state == DACC) && !r_write);
    assign ramWEN   = (r_state == DACC) && r_write;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_request_responder.sv
// Randomized scoreboard bench for mem_request_responder with a behavioural
// RAM and a requester-level reference model.
module tb_mem_request_responder;

    localparam int          TIMEOUT = 8;
    localparam logic [31:0] BAD     = 32'hBAD1_BAD1;

    logic        CLK, RST;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit;
    logic [31:0] imemload, dmemload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic        ram_ready;
    logic        err;

    mem_request_responder #(
        .WORD_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .ihit      (ihit),
        .dhit      (dhit),
        .imemload  (imemload),
        .dmemload  (dmemload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready),
        .err       (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          n_txn = 0;
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] iexp_q [$];
    logic [31:0] dexp_q [$];
    bit          order_q [$];     // 1 = data side expected next
    bit          m_last_d;
    bit          m_err;
    bit          no_ready;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int dly_of(input logic [31:0] a);
        return int'(a[3:2]) + 1;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model plus output monitor, both sampling on the falling edge.
    task automatic env_loop();
        int acc_cnt = 0;
        int exp_len = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                acc_cnt   = 0;
                ram_ready = 1'b0;
            end else begin
                if (ramREN || ramWEN) begin
                    if (acc_cnt == 0) exp_len = no_ready ? TIMEOUT : dly_of(ramaddr);
                    acc_cnt++;
                    if (!no_ready && acc_cnt == exp_len) begin
                        ram_ready = 1'b1;
                        if (ramWEN) ram_mem[ramaddr] = ramstore;
                        else        ramload = ram_rd(ramaddr);
                    end else begin
                        ram_ready = 1'b0;
                        ramload   = $urandom;
                    end
                end else begin
                    if (acc_cnt != 0) chk("strobe_len", 64'(acc_cnt), 64'(exp_len));
                    acc_cnt   = 0;
                    ram_ready = 1'b0;
                end

                chk("hit_exclusive", 64'(ihit & dhit), 64'd0);
                chk("strobe_exclusive", 64'(ramREN & ramWEN), 64'd0);
                if (ihit) begin
                    if (order_q.size() == 0 || iexp_q.size() == 0) begin
                        chk("unexpected_ihit", 64'(ihit), 64'd0);
                    end else begin
                        chk("grant_order_i", 64'(order_q.pop_front()), 64'd0);
                        chk("imemload", 64'(imemload), 64'(iexp_q.pop_front()));
                    end
                end
                if (dhit) begin
                    if (order_q.size() == 0 || dexp_q.size() == 0) begin
                        chk("unexpected_dhit", 64'(dhit), 64'd0);
                    end else begin
                        chk("grant_order_d", 64'(order_q.pop_front()), 64'd1);
                        chk("dmemload", 64'(dmemload), 64'(dexp_q.pop_front()));
                    end
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {59'd0, ihit, dhit, ramREN, ramWEN, err}, 64'd0);
        chk({tag, "_loads"}, {imemload, dmemload}, 64'd0);
        chk({tag, "_rambus"}, {ramaddr, ramstore}, 64'd0);
    endtask

    // Issue one request set, hold each side until its hit, then release it.
    task automatic run_txn(input bit use_i, input bit d_rd, input bit d_wr,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] ds, input bit to);
        bit use_d, first_d, ip, dpn, di, dd;
        int cyc, exp_lat;
        use_d = d_rd | d_wr;
        if (use_i && use_d) begin
            first_d = !m_last_d;
            order_q.push_back(first_d);
            order_q.push_back(!first_d);
            m_last_d = !first_d;
        end else if (use_i) begin
            order_q.push_back(1'b0);
            m_last_d = 1'b0;
        end else begin
            order_q.push_back(1'b1);
            m_last_d = 1'b1;
        end
        if (use_i) iexp_q.push_back(to ? BAD : ref_rd(ia));
        if (use_d) begin
            if (d_wr) begin
                dexp_q.push_back(32'd0);
                if (!to) ref_mem[da] = ds;
            end else begin
                dexp_q.push_back(to ? BAD : ref_rd(da));
            end
            if (d_rd && d_wr) m_err = 1'b1;
        end
        if (to) m_err = 1'b1;
        exp_lat = 2 + (to ? TIMEOUT : dly_of(use_i ? ia : da));

        n_txn++;
        $display("txn %0d: i=%0b ia=%h d_rd=%0b d_wr=%0b da=%h ds=%h timeout=%0b",
                 n_txn, use_i, ia, d_rd, d_wr, da, ds, to);
        no_ready  = to;
        imemREN   = use_i;
        imemaddr  = ia;
        dmemREN   = d_rd;
        dmemWEN   = d_wr;
        dmemaddr  = da;
        dmemstore = ds;
        ip  = use_i;
        dpn = use_d;
        cyc = 0;
        while ((ip || dpn) && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            di = 1'b0;
            dd = 1'b0;
            if (ip && ihit) begin
                ip = 1'b0;
                di = 1'b1;
                if (!use_d) chk("latency_i", 64'(cyc), 64'(exp_lat));
            end
            if (dpn && dhit) begin
                dpn = 1'b0;
                dd  = 1'b1;
                if (!use_i) chk("latency_d", 64'(cyc), 64'(exp_lat));
            end
            @(posedge CLK);
            #1;
            if (di) imemREN = 1'b0;
            if (dd) begin
                dmemREN = 1'b0;
                dmemWEN = 1'b0;
            end
        end
        if (ip || dpn) begin
            chk("hit_wait_expired", 64'({ip, dpn}), 64'd0);
            imemREN = 1'b0;
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
        end
        no_ready = 1'b0;
        chk("err_flag", 64'(err), 64'(m_err));
    endtask

    task automatic rand_phase(input int n);
        int k;
        logic [31:0] ia, da, ds;
        for (int t = 0; t < n; t++) begin
            k  = $urandom_range(0, 8);
            ia = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            da = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            ds = $urandom;
            if (k < 3)      run_txn(1'b1, 1'b0, 1'b0, ia, da, ds, 1'b0);
            else if (k < 6) begin
                if (k[0]) run_txn(1'b0, 1'b0, 1'b1, ia, da, ds, 1'b0);
                else      run_txn(1'b0, 1'b1, 1'b0, ia, da, ds, 1'b0);
            end else begin
                if (k[0]) run_txn(1'b1, 1'b0, 1'b1, ia, da, ds, 1'b0);
                else      run_txn(1'b1, 1'b1, 1'b0, ia, da, ds, 1'b0);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic withdraw_test();
        int cyc = 0;
        int hits = 0;
        n_txn++;
        $display("txn %0d: instruction request withdrawn during access", n_txn);
        imemREN  = 1'b1;
        imemaddr = 32'h48;
        while (!ramREN && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("withdraw_strobe_seen", 64'(ramREN), 64'd1);
        @(posedge CLK);
        #1;
        imemREN  = 1'b0;
        m_last_d = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (ihit) hits++;
        end
        chk("withdraw_no_ihit", 64'(hits), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_mid_access_test();
        int cyc = 0;
        n_txn++;
        $display("txn %0d: reset asserted during data access", n_txn);
        no_ready = 1'b1;
        dmemREN  = 1'b1;
        dmemaddr = 32'h108;
        while (!ramREN && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("reset_test_strobe_seen", 64'(ramREN), 64'd1);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        RST     = 1'b1;
        dmemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        no_ready = 1'b0;
        m_last_d = 1'b0;
        m_err    = 1'b0;
        @(negedge CLK);
        check_idle_outputs("after_mid_reset");
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST       = 1'b1;
        imemREN   = 1'b0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        imemaddr  = '0;
        dmemaddr  = '0;
        dmemstore = '0;
        ramload   = '0;
        ram_ready = 1'b0;
        no_ready  = 1'b0;
        m_last_d  = 1'b0;
        m_err     = 1'b0;
        fork
            env_loop();
        join_none
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Both sides from reset: data wins the first tie, then alternation.
        run_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 32'h44, 32'h104, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, 1'b0);
        rand_phase(60);

        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h10C, 32'h0, 1'b1);
        run_txn(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h110, 32'h1234_5678, 1'b1);
        rand_phase(30);

        withdraw_test();
        run_txn(1'b1, 1'b0, 1'b0, 32'h4C, 32'h0, 32'h0, 1'b0);

        reset_mid_access_test();
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h114, 32'hCAFE_F00D, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h114, 32'h0, 1'b0);
        rand_phase(20);

        repeat (4) @(posedge CLK);
        chk("iexp_drained", 64'(iexp_q.size()), 64'd0);
        chk("dexp_drained", 64'(dexp_q.size()), 64'd0);
        chk("order_drained", 64'(order_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_request_responder.md
Name: mem_request_responder

Overview:
- Memory-side endpoint of the request-unit handshake. It accepts imemREN, dmemREN and dmemWEN plus addresses and store data from the datapath request unit.
- It arbitrates between the instruction and data requests onto a single RAM port, waits for RAM completion, then returns a one-cycle ihit or dhit together with the load data.
- It sits between the request unit and the RAM model, and has a timeout watchdog.

Parameters:
WORD_W, 32, address/data width in bits
TIMEOUT, 64, max cycles waiting for ram_ready before aborting the access (≥2)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
imemREN  in  1  instruction read request (level, held until ihit)
imemaddr  in  WORD_W  instruction address
dmemREN  in  1  data read request (level)
dmemWEN  in  1  data write request (level)
dmemaddr  in  WORD_W  data address
dmemstore  in  WORD_W  data to write
ihit  out  1  one-cycle instruction completion pulse
dhit  out  1  one-cycle data completion pulse
imemload  out  WORD_W  instruction word, valid while ihit=1
dmemload  out  WORD_W  read data, valid while dhit=1 on reads
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data, valid with ram_ready
ram_ready  in  1  RAM completion pulse
err  out  1  sticky error flag (timeout or illegal dREN+dWEN)

Behaviour:
- Reset (RST=1 at edge): state=IDLE; ihit, dhit, ramREN, ramWEN, and err are 0; imemload, dmemload, ramaddr, and ramstore are 0; the wait counter is 0; last_grant=I. RST mid-access aborts at once with no hit, and the RAM strobes drop the next cycle.
- States: IDLE, IACC, DACC, RESP.
- IDLE:
  - Sample requests. Data pending = dmemREN|dmemWEN.
  - If only one side is pending, grant it.
  - If both are pending, grant the side opposite last_grant (alternation). The first tie after reset goes to D.
  - A grant latches the address, store data, and op (read or write) into registers, drives the RAM strobes from the next cycle, and moves to IACC or DACC.
- Illegal dmemREN=dmemWEN=1 is treated as a write and sets err.
- IACC/DACC:
  - ramREN (or ramWEN) is held high with the latched address and data.
  - The wait counter increments each cycle.
  - On ram_ready=1: capture ramload, drop the strobes next cycle, go to RESP.
  - If the counter reaches TIMEOUT-1 without ram_ready: set err, capture 0xBAD1BAD1 (truncated to WORD_W) as load, go to RESP.
- RESP (exactly 1 cycle):
  - Pulse the matching hit, only if the originating request is still asserted this cycle. A withdrawn request completes on RAM but its hit is discarded.
  - imemload or dmemload is driven with the captured word. For writes, dmemload=0.
  - Update last_grant, clear the counter, return to IDLE.
- Latency: minimum 3 cycles from request-visible to hit: IDLE grant, ACC with ram_ready in the first ACC cycle, then RESP. The requester must deassert or change its request on the hit cycle. A request still high in the following IDLE is treated as new.
- Requests arriving during IACC, DACC, or RESP wait. They are never lost while held.
- ihit and dhit are never high in the same cycle. ramREN and ramWEN are never both high.
- err clears only on RST.

Decomposition:
- Shared package mem_resp_pkg: state enum (IDLE, IACC, DACC, RESP), grant enum (GRANT_I, GRANT_D), the BAD_WORD constant, and the default WORD_W.
- One natural sub-module: mem_wait_timer (load/clear, increment, terminal-count flag at TIMEOUT-1).
- Arbitration and the FSM remain in the top module.

Test Plan:
- imemREN=1, imemaddr=0x40; RAM returns ram_ready on the first ACC cycle with ramload=0x8C010004 -> ramREN high 1 cycle with ramaddr=0x40; ihit=1, imemload=0x8C010004 on cycle 3; dhit=0.
- dmemWEN=1, dmemaddr=0x100, dmemstore=0xDEADBEEF; RAM ready after 4 cycles -> ramWEN high 4 cycles with those values; dhit on the following cycle; dmemload=0; err=0.
- imemREN and dmemREN both high from reset -> D served first (dhit), then I (ihit), each 3+ cycles apart; repeat both held -> grants alternate D,I,D,I.
- TIMEOUT=8, dmemREN=1, ram_ready never asserted -> strobe high exactly 8 cycles; dhit=1, dmemload=0xBAD1BAD1, err=1 and stays 1 until RST.
- imemREN dropped during IACC, ram_ready arrives -> no ihit; FSM returns to IDLE; the next request is served normally.
- RST=1 during DACC -> next cycle all outputs 0, state IDLE, no hit; dmemREN=dmemWEN=1 afterwards -> write performed, err=1.
